omok_turn_sequencer: RTL and testbench



---
 rtl/omok_turn_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_omok_turn_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/omok_turn_sequencer.sv
// rtl/omok_turn_sequencer.sv - Omok move/undo/new-game sequencer with incremental win scan
// Drives the single board port; after each placement walks outward one cell per cycle.
module omok_turn_sequencer #(
  parameter int MAP_N   = 10,
  parameter int WIN_LEN = 5,
  parameter int POS_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             put_req,
  input  logic [POS_W-1:0] pos_in,
  input  logic             undo_req,
  input  logic             new_game,
  output logic [POS_W-1:0] rd_addr,
  input  logic [1:0]       rd_data,
  output logic             wr_en,
  output logic [POS_W-1:0] wr_addr,
  output logic [1:0]       wr_data,
  output logic             busy,
  output logic             turn_black,
  output logic             black_win,
  output logic             white_win,
  output logic             game_over,
  output logic [6:0]       move_count,
  output logic             reject
);

  localparam int CELLS = MAP_N * MAP_N;
  localparam logic signed [5:0] N_S = 6'(MAP_N);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_CHECK, S_WRITE, S_SCAN, S_RESULT, S_UNDO
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   clr_idx_q, clr_idx_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic signed [5:0]  row_q, row_d, col_q, col_d;
  logic signed [5:0]  cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [1:0]         dir_q, dir_d;
  logic               back_q, back_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               win_q, win_d;
  logic               turn_black_q, turn_black_d;
  logic               black_win_q, black_win_d;
  logic               white_win_q, white_win_d;
  logic [6:0]         move_count_q, move_count_d;
  logic               reject_q, reject_d;
  logic [POS_W-1:0]   hist_q [CELLS];

  logic signed [5:0]  dr, dc, nr, nc;
  logic               in_bounds;
  logic [POS_W-1:0]   nb_addr;
  logic [1:0]         mover;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      clr_idx_q    <= '0;
      pos_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      cur_row_q    <= '0;
      cur_col_q    <= '0;
      dir_q        <= '0;
      back_q       <= 1'b0;
      cnt_q        <= 4'd1;
      win_q        <= 1'b0;
      turn_black_q <= 1'b1;
      black_win_q  <= 1'b0;
      white_win_q  <= 1'b0;
      move_count_q <= '0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      pos_q        <= pos_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      dir_q        <= dir_d;
      back_q       <= back_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      turn_black_q <= turn_black_d;
      black_win_q  <= black_win_d;
      white_win_q  <= white_win_d;
      move_count_q <= move_count_d;
      reject_q     <= reject_d;
    end
  end

  // Move history doubles as the undo stack; move_count is its pointer.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE) hist_q[move_count_q] <= pos_q;
  end

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    pos_d        = pos_q;
    row_d        = row_q;
    col_d        = col_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    dir_d        = dir_q;
    back_d       = back_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    turn_black_d = turn_black_q;
    black_win_d  = black_win_q;
    white_win_d  = white_win_q;
    move_count_d = move_count_q;
    reject_d     = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = pos_q;
    wr_data      = 2'b00;
    rd_addr      = pos_q;
    mover        = turn_black_q ? 2'b10 : 2'b11;

    case (dir_q)
      2'd0:    begin dr = 6'sd0;  dc = 6'sd1; end
      2'd1:    begin dr = 6'sd1;  dc = 6'sd0; end
      2'd2:    begin dr = 6'sd1;  dc = 6'sd1; end
      default: begin dr = -6'sd1; dc = 6'sd1; end
    endcase
    if (back_q) begin
      dr = -dr;
      dc = -dc;
    end
    nr        = cur_row_q + dr;
    nc        = cur_col_q + dc;
    in_bounds = !nr[5] && (nr < N_S) && !nc[5] && (nc < N_S);
    nb_addr   = POS_W'($unsigned(nr)) * POS_W'(MAP_N) + POS_W'($unsigned(nc));

    case (state_q)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_idx_q;
        if (clr_idx_q == POS_W'(CELLS - 1)) state_d = S_IDLE;
        else clr_idx_d = clr_idx_q + 1'b1;
      end
      S_IDLE: begin
        if (put_req) begin
          if (black_win_q || white_win_q || pos_in >= POS_W'(CELLS)) begin
            reject_d = 1'b1;
          end else begin
            pos_d   = pos_in;
            row_d   = $signed(6'(pos_in / POS_W'(MAP_N)));
            col_d   = $signed(6'(pos_in % POS_W'(MAP_N)));
            state_d = S_CHECK;
          end
        end else if (undo_req) begin
          if (move_count_q == 7'd0 || black_win_q || white_win_q) reject_d = 1'b1;
          else state_d = S_UNDO;
        end
      end
      S_CHECK: begin
        if (rd_data != 2'b00) begin
          reject_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en        = 1'b1;
        wr_data      = mover;
        move_count_d = move_count_q + 7'd1;
        dir_d        = 2'd0;
        back_d       = 1'b0;
        cnt_d        = 4'd1;
        win_d        = 1'b0;
        cur_row_d    = row_q;
        cur_col_d    = col_q;
        state_d      = S_SCAN;
      end
      S_SCAN: begin
        rd_addr = nb_addr;
        if (in_bounds && rd_data == mover) begin
          cnt_d     = cnt_q + 4'd1;
          cur_row_d = nr;
          cur_col_d = nc;
          if (cnt_q + 4'd1 == 4'(WIN_LEN)) begin
            win_d   = 1'b1;
            state_d = S_RESULT;
          end
        end else if (!back_q) begin
          back_d    = 1'b1;
          cur_row_d = row_q;
          cur_col_d = col_q;
        end else if (dir_q == 2'd3) begin
          state_d = S_RESULT;
        end else begin
          dir_d     = dir_q + 2'd1;
          back_d    = 1'b0;
          cnt_d     = 4'd1;
          cur_row_d = row_q;
          cur_col_d = col_q;
        end
      end
      S_RESULT: begin
        if (win_q) begin
          if (turn_black_q) black_win_d = 1'b1;
          else white_win_d = 1'b1;
        end else begin
          turn_black_d = !turn_black_q;
        end
        state_d = S_IDLE;
      end
      S_UNDO: begin
        wr_en        = 1'b1;
        wr_addr      = hist_q[move_count_q - 7'd1];
        move_count_d = move_count_q - 7'd1;
        turn_black_d = !turn_black_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase

    // new_game outranks everything, including a clear already in progress.
    if (new_game) begin
      state_d      = S_CLEAR;
      clr_idx_d    = '0;
      reject_d     = 1'b0;
      turn_black_d = 1'b1;
      black_win_d  = 1'b0;
      white_win_d  = 1'b0;
      move_count_d = '0;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign turn_black = turn_black_q;
  assign black_win  = black_win_q;
  assign white_win  = white_win_q;
  assign game_over  = black_win_q | white_win_q;
  assign move_count = move_count_q;
  assign reject     = reject_q;

endmodule

// File: tb/tb_omok_turn_sequencer.sv
// tb/tb_omok_turn_sequencer.sv - directed self-checking bench for omok_turn_sequencer
module tb_omok_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       put_req, undo_req, new_game;
  logic [7:0] pos_in;
  logic [7:0] rd_addr, wr_addr;
  logic [1:0] rd_data, wr_data;
  logic       wr_en, busy, turn_black, black_win, white_win, game_over, reject;
  logic [6:0] move_count;
  logic [1:0] mem [0:255];
  int         checks = 0;
  int         failures = 0;
  int         bad;

  omok_turn_sequencer dut (
    .clk(clk), .rst(rst), .put_req(put_req), .pos_in(pos_in), .undo_req(undo_req),
    .new_game(new_game), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .turn_black(turn_black),
    .black_win(black_win), .white_win(white_win), .game_over(game_over),
    .move_count(move_count), .reject(reject)
  );

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];
  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

  task automatic chk(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
    checks++;
    assert (obsv === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obsv, expv);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic place(input int p);
    @(negedge clk);
    put_req = 1'b1;
    pos_in  = 8'(p);
    @(negedge clk);
    put_req = 1'b0;
    wait_idle("place");
  endtask

  task automatic undo_pulse();
    @(negedge clk);
    undo_req = 1'b1;
    @(negedge clk);
    undo_req = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("ng_busy", 32'(busy), 32'd1);
    wait_idle("clear");
  endtask

  initial begin
    rst = 1'b1; put_req = 1'b0; undo_req = 1'b0; new_game = 1'b0; pos_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_turn", 32'(turn_black), 32'd1);
    chk("rst_count", 32'(move_count), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);

    // 1: clear sweep 0..99 right after reset release
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!(busy === 1'b1 && wr_en === 1'b1 && wr_addr === 8'(i) && wr_data === 2'b00)) bad++;
      @(negedge clk);
    end
    chk("clear_seq", 32'(bad), 32'd0);
    chk("clear_done_busy", 32'(busy), 32'd0);
    chk("clear_done_wr", 32'(wr_en), 32'd0);
    chk("clear_done_turn", 32'(turn_black), 32'd1);

    // 2: isolated black at 44, exact latency
    @(negedge clk); put_req = 1'b1; pos_in = 8'd44;
    @(negedge clk); put_req = 1'b0;
    chk("p44_c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("p44_c2_wr_en", 32'(wr_en), 32'd1);
    chk("p44_c2_addr", 32'(wr_addr), 32'd44);
    chk("p44_c2_data", 32'(wr_data), 32'd2);
    bad = 0;
    for (int c = 3; c <= 11; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) bad++;
    end
    chk("p44_busy_3_11", 32'(bad), 32'd0);
    @(negedge clk);
    chk("p44_c12_busy", 32'(busy), 32'd0);
    chk("p44_turn", 32'(turn_black), 32'd0);
    chk("p44_count", 32'(move_count), 32'd1);

    // 3: occupied cell rejected after CHECK; out-of-range rejected straight from IDLE
    @(negedge clk); put_req = 1'b1; pos_in = 8'd44;
    @(negedge clk); put_req = 1'b0;
    chk("dup_c1_rej", 32'(reject), 32'd0);
    @(negedge clk);
    chk("dup_c2_rej", 32'(reject), 32'd1);
    chk("dup_c2_wr", 32'(wr_en), 32'd0);
    chk("dup_c2_busy", 32'(busy), 32'd0);
    chk("dup_turn", 32'(turn_black), 32'd0);
    @(negedge clk); put_req = 1'b1; pos_in = 8'd120;
    @(negedge clk); put_req = 1'b0;
    chk("oor_rej", 32'(reject), 32'd1);
    chk("oor_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("oor_rej_pulse", 32'(reject), 32'd0);
    chk("oor_count", 32'(move_count), 32'd1);

    // 4: horizontal black win at 40..44
    restart();
    place(40); place(50); place(41); place(51); place(42); place(52); place(43); place(53);
    chk("pre_win_over", 32'(game_over), 32'd0);
    place(44);
    chk("hwin_black", 32'(black_win), 32'd1);
    chk("hwin_white", 32'(white_win), 32'd0);
    chk("hwin_over", 32'(game_over), 32'd1);
    chk("hwin_turn", 32'(turn_black), 32'd1);
    chk("hwin_count", 32'(move_count), 32'd9);
    @(negedge clk); put_req = 1'b1; pos_in = 8'd60;
    @(negedge clk); put_req = 1'b0;
    chk("over_put_rej", 32'(reject), 32'd1);
    undo_pulse();
    chk("over_undo_rej", 32'(reject), 32'd1);
    chk("over_undo_count", 32'(move_count), 32'd9);
    restart();
    chk("ng_black_win", 32'(black_win), 32'd0);
    chk("ng_over", 32'(game_over), 32'd0);
    chk("ng_count", 32'(move_count), 32'd0);
    chk("ng_turn", 32'(turn_black), 32'd1);

    // 5: 7..11 crosses a row boundary and must not win
    place(7); place(90); place(8); place(92); place(9); place(94); place(10); place(96); place(11);
    chk("wrap_nowin", 32'(game_over), 32'd0);
    chk("wrap_count", 32'(move_count), 32'd9);
    chk("wrap_turn", 32'(turn_black), 32'd0);
    restart();
    place(4); place(90); place(13); place(92); place(22); place(94); place(31); place(96); place(40);
    chk("anti_diag_black", 32'(black_win), 32'd1);
    chk("anti_diag_white", 32'(white_win), 32'd0);

    // 6: undo path, empty-undo reject, abort mid-scan
    restart();
    undo_pulse();
    chk("undo_empty_rej", 32'(reject), 32'd1);
    place(44); place(45); place(46);
    chk("three_count", 32'(move_count), 32'd3);
    chk("three_turn", 32'(turn_black), 32'd0);
    undo_pulse();
    chk("undo_wr_en", 32'(wr_en), 32'd1);
    chk("undo_addr", 32'(wr_addr), 32'd46);
    chk("undo_data", 32'(wr_data), 32'd0);
    @(negedge clk);
    chk("undo_count", 32'(move_count), 32'd2);
    chk("undo_turn", 32'(turn_black), 32'd1);
    chk("undo_busy", 32'(busy), 32'd0);
    undo_pulse(); @(negedge clk);
    chk("undo2_addr_state", 32'(move_count), 32'd1);
    undo_pulse();
    chk("undo3_addr", 32'(wr_addr), 32'd44);
    @(negedge clk);
    chk("undo3_count", 32'(move_count), 32'd0);
    chk("undo3_turn", 32'(turn_black), 32'd1);
    undo_pulse();
    chk("undo_zero_rej", 32'(reject), 32'd1);

    place(40); place(50); place(41); place(51); place(42); place(52); place(43); place(53);
    @(negedge clk); put_req = 1'b1; pos_in = 8'd44;
    @(negedge clk); put_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_scan_busy", 32'(busy), 32'd1);
    new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    chk("abort_clear_wr", 32'(wr_en), 32'd1);
    chk("abort_clear_addr", 32'(wr_addr), 32'd0);
    chk("abort_no_win", 32'(game_over), 32'd0);
    wait_idle("abort");
    chk("abort_final_win", 32'(black_win), 32'd0);
    chk("abort_final_count", 32'(move_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
